pulse_evt_queue: RTL and testbench
==================================

# pulse_evt_queue

Downstream consumer of the double-flip-flop pulse synchronizer. It takes the one-cycle synchronized pulses and counts them as pending events. It presents those events to a local consumer through a valid/ready handshake, one event per transfer, so no pulse is lost when the consumer stalls. It also keeps a free-running total of received pulses and a sticky overflow flag for events dropped when the pending queue is full.

## Interface
Parameters:
- CNT_W, 4: width of the pending-event counter; capacity PMAX = 2^CNT_W − 1 events.
- TOT_W, 16: width of the total-pulse counter; wraps modulo 2^TOT_W.

Ports:
- clk  input  1  system clock; the block's only clock.
- resetb  input  1  reset, synchronous, active-low.
- pulse_in  input  1  synchronized pulse; each cycle it is high counts as one event.
- evt_valid  output  1  at least one event is pending.
- evt_ready  input  1  consumer accepts one event when high together with evt_valid.
- pending  output  CNT_W  number of events currently pending.
- total  output  TOT_W  count of all pulse_in cycles seen since reset, including dropped ones.
- overflow  output  1  sticky; set when an event was dropped.
- clr_ovf  input  1  clears overflow.

## Operation
- All state is in registers updated on posedge clk. No output depends combinationally on any input.
- pop = evt_valid & evt_ready. A pop when evt_valid = 0 is ignored.
- push = pulse_in.
- Pending counter update per cycle:
  - push only, pending < PMAX: pending + 1.
  - push only, pending = PMAX: unchanged, and overflow is set.
  - pop only: pending − 1.
  - push and pop together: unchanged. This holds at PMAX too, with no overflow.
  - neither: unchanged.
- evt_valid = (pending != 0). It is decoded from the pending register.
- total increments on every push, whether accepted or dropped, and wraps from 2^TOT_W − 1 to 0.
- Overflow register:
  - overflow <= set | (overflow & ~clr_ovf).
  - A drop in the same cycle as clr_ovf leaves overflow = 1.
- Derived states, with no separate state register:
  - EMPTY (pending = 0).
  - BUSY (0 < pending < PMAX).
  - FULL (pending = PMAX).
- State transitions:
  - EMPTY→BUSY on push.
  - BUSY→EMPTY on pop with pending = 1 and no push.
  - BUSY→FULL on push without pop at PMAX − 1.
  - FULL→BUSY on pop without push.
  - With CNT_W = 1, EMPTY and FULL alternate directly.
- Reset, when resetb = 0 at a clock edge:
  - pending, total and overflow go to 0; evt_valid goes to 0.
  - pulse_in, evt_ready and clr_ovf are ignored in that cycle.
  - This applies mid-transfer too: pending events are discarded.

## Timing
- Push latency: pulse_in high in the cycle before edge N gives pending, total and evt_valid updated immediately after edge N, a 1-cycle latency.
- Pop: the handshake completes at the edge where evt_valid & evt_ready = 1. pending reflects the pop after that edge.
- Back-to-back pops: evt_ready held high drains one event per cycle.
- evt_valid may drop only after the edge that consumes the last event.
- Overflow asserts 1 cycle after the dropping push. It clears 1 cycle after a clr_ovf that has no concurrent drop.
- Reset is synchronous: all outputs are 0 after the first edge sampled with resetb = 0, and they stay 0 while resetb = 0.

## Test plan
- Reset, then 3 isolated pulses with evt_ready = 0 → pending = 3, total = 3, evt_valid = 1, overflow = 0.
- Raise evt_ready for 5 cycles after the above → exactly 3 pops; pending = 0 and evt_valid = 0 after the 3rd edge; total stays 3.
- CNT_W = 4, 17 pulses with evt_ready = 0 → pending = 15, total = 17, overflow = 1. Then pulse and evt_ready together at FULL → pending stays 15, total = 18.
- pulse_in and evt_ready high together for 10 cycles from pending = 2 → pending stays 2 and evt_valid stays 1 throughout; 10 transfers complete.
- Assert clr_ovf in the same cycle as a drop at FULL → overflow stays 1. Then clr_ovf with no drop → overflow = 0 after the next edge.
- TOT_W = 4, 17 pulses with evt_ready = 1 → total = 1 (wrapped). Assert resetb = 0 at pending = 5 → all outputs 0 after that edge, with evt_ready high during reset having no effect.

Source files
------------

// File: rtl/pulse_evt_queue.sv
// Pending-event counter behind a pulse synchronizer. It hands events to a
// consumer over valid/ready, counts every pulse, and flags drops while full.
module pulse_evt_queue #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TOT_W = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             pulse_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic [TOT_W-1:0] total,
  output logic             overflow,
  input  logic             clr_ovf
);

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} occ_e;

  localparam logic [CNT_W-1:0] PMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] pending_q, pending_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;
  occ_e             occ;

  // Occupancy is decoded from the counter; there is no separate state register.
  always_comb begin
    occ = StBusy;
    if (pending_q == '0) begin
      occ = StEmpty;
    end else if (pending_q == PMax) begin
      occ = StFull;
    end
  end

  assign evt_valid = (occ != StEmpty);
  assign push      = pulse_in;
  assign pop       = evt_valid & evt_ready;

  always_comb begin
    pending_d = pending_q;
    drop      = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (occ == StFull) begin
          drop = 1'b1;
        end else begin
          pending_d = pending_q + CNT_W'(1);
        end
      end
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  // Total counts dropped pulses too and wraps naturally.
  assign total_d    = total_q + TOT_W'(push);
  // A drop wins over a concurrent clear.
  assign overflow_d = drop | (overflow_q & ~clr_ovf);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      pending_q  <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign total    = total_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_evt_queue.sv
// Scoreboard bench for pulse_evt_queue: the driver queues hand-computed
// expectations per cycle; a negedge monitor pops and compares them.
module tb_pulse_evt_queue;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        pulse_in = 1'b0;
  logic        evt_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        evt_valid, overflow;
  logic [3:0]  pending;
  logic [15:0] total;
  logic        evt_valid_b, overflow_b;
  logic [3:0]  pending_b;
  logic [3:0]  total_b;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;

  typedef struct {
    int pend;
    int tot;
    int ovf;
    int xfer;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pulse_evt_queue #(.CNT_W(4), .TOT_W(16)) u_dut (
    .clk       (clk),
    .resetb    (resetb),
    .pulse_in  (pulse_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .total     (total),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  pulse_evt_queue #(.CNT_W(4), .TOT_W(4)) u_dut_t4 (
    .clk       (clk),
    .resetb    (resetb),
    .pulse_in  (pulse_in),
    .evt_valid (evt_valid_b),
    .evt_ready (evt_ready),
    .pending   (pending_b),
    .total     (total_b),
    .overflow  (overflow_b),
    .clr_ovf   (clr_ovf)
  );

  // Count completed handshakes as seen at the active edge.
  always @(posedge clk) begin
    if (resetb && evt_valid && evt_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pending", int'(pending), e.pend);
      check("total", int'(total), e.tot);
      check("overflow", int'(overflow), e.ovf);
      check("evt_valid", int'(evt_valid), (e.pend != 0) ? 1 : 0);
      check("xfers", xfer_cnt, e.xfer);
      check("total_w4", int'(total_b), e.tot % 16);
      check("pending_w4", int'(pending_b), e.pend);
      check("overflow_w4", int'(overflow_b), e.ovf);
      check("evt_valid_w4", int'(evt_valid_b), (e.pend != 0) ? 1 : 0);
    end
  end

  // Drive one cycle and queue the state expected right after its edge.
  task automatic step(input logic p, input logic r, input logic c, input logic rb,
                      input int ep, input int et, input int eo, input int ex);
    exp_t e;
    pulse_in  = p;
    evt_ready = r;
    clr_ovf   = c;
    resetb    = rb;
    e.pend = ep;
    e.tot  = et;
    e.ovf  = eo;
    e.xfer = ex;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset; inputs high during the second reset cycle must be ignored.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);

    // Three isolated pulses, consumer stalled.
    step(1, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 2, 2, 0, 0);
    step(0, 0, 0, 1, 2, 2, 0, 0);
    step(1, 0, 0, 1, 3, 3, 0, 0);
    step(0, 0, 0, 1, 3, 3, 0, 0);

    // Ready for 5 cycles: exactly three pops.
    step(0, 1, 0, 1, 2, 3, 0, 1);
    step(0, 1, 0, 1, 1, 3, 0, 2);
    step(0, 1, 0, 1, 0, 3, 0, 3);
    step(0, 1, 0, 1, 0, 3, 0, 3);
    step(0, 1, 0, 1, 0, 3, 0, 3);

    // 17 pulses from empty: saturates at 15, the 16th pulse drops.
    for (int i = 1; i <= 17; i++) begin
      step(1, 0, 0, 1, (i > 15) ? 15 : i, 3 + i, (i >= 16) ? 1 : 0, 3);
    end

    // Push and pop together at FULL: no change, no extra drop.
    step(1, 1, 0, 1, 15, 21, 1, 4);
    // Clear in the same cycle as a drop: overflow stays set.
    step(1, 0, 1, 1, 15, 22, 1, 4);
    // Clear with no drop.
    step(0, 0, 1, 1, 15, 22, 0, 4);
    step(0, 0, 0, 1, 15, 22, 0, 4);

    // Drain 13 events down to pending = 2.
    for (int i = 1; i <= 13; i++) begin
      step(0, 1, 0, 1, 15 - i, 22, 0, 4 + i);
    end

    // Simultaneous push and pop for 10 cycles at pending = 2.
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 0, 1, 2, 22 + i, 0, 17 + i);
    end

    // Drain; a ready with nothing pending is not a transfer.
    step(0, 1, 0, 1, 1, 32, 0, 28);
    step(0, 1, 0, 1, 0, 32, 0, 29);
    step(0, 1, 0, 1, 0, 32, 0, 29);

    // Reset, then 17 pulses with ready high: pending holds at 1, the 4-bit total wraps.
    step(0, 0, 0, 0, 0, 0, 0, 29);
    for (int i = 1; i <= 17; i++) begin
      step(1, 1, 0, 1, 1, i, 0, 29 + i - 1);
    end

    // Build pending up to 5, then reset with ready and pulse high.
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 1, 1 + i, 17 + i, 0, 45);
    end
    step(1, 1, 1, 0, 0, 0, 0, 45);
    step(1, 1, 0, 0, 0, 0, 0, 45);
    step(0, 0, 0, 1, 0, 0, 0, 45);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
